alu_item_sequencer: RTL
=======================

// Module: alu_item_sequencer
// PURPOSE
//  Upstream command stage for the ALU bfm. Accepts one packed TLM packet of NUM items
//  (op, A, B bytes each) on a valid/ready handshake. Issues the items to the bfm one at a
//  time over its start/done protocol and returns each 16-bit result tagged with its item
//  index. Raises pkt_ready_o again only after the last result has returned.
// PARAMETERS
//  NUM         100  items per packet (>=1)
//  ITEM_WIDTH  8    bits per byte slot; op, A and B each occupy one slot
//  OP_WIDTH    3    op bits taken from the LSBs of the op slot; upper bits ignored
//  RES_WIDTH   16   bfm result width
//  TIMEOUT     64   max WAIT cycles per item (used only with ALU_SEQ_TIMEOUT_EN)
// PORTS
//  clk_i          in   1                     clock, rising edge
//  reset_i        in   1                     async reset, active-low
//  pkt_valid_i    in   1                     packet present
//  pkt_ready_o    out  1                     sequencer idle, packet accepted on valid&ready
//  pkt_data_i     in   NUM*3*ITEM_WIDTH      slot k = [k*ITEM_WIDTH +: ITEM_WIDTH]; item n: op=3n, A=3n+1, B=3n+2
//  op_s           out  OP_WIDTH              bfm opcode
//  A_s            out  ITEM_WIDTH            bfm operand A
//  B_s            out  ITEM_WIDTH            bfm operand B
//  start          out  1                     one-cycle issue pulse to the bfm
//  done           in   1                     bfm completion, sampled only in WAIT
//  res_i          in   RES_WIDTH             bfm result, valid with done
//  res_valid_o    out  1                     one-cycle result pulse
//  res_o          out  RES_WIDTH             captured result
//  item_idx_o     out  $clog2(NUM)(min 1)    index of the item that res_o belongs to
//  pkt_done_o     out  1                     one-cycle pulse with the last item's res_valid_o
//  err_timeout_o  out  1                     sticky timeout flag (tied 0 without the macro)
// BEHAVIOUR
//  Reset, asynchronous on reset_i=0: state IDLE. Every output and the idx counter clear
//   to 0, including pkt_ready_o. The payload register is not reset.
//  Reset mid-packet: the packet is dropped and no further start is issued.
//   After release, pkt_ready_o goes to 1 on the first clock edge.
//  FSM IDLE -> ISSUE -> WAIT -> (ISSUE | IDLE).
//  IDLE: pkt_ready_o=1. On pkt_valid_i&&pkt_ready_o: capture pkt_data_i, set idx=0,
//   drop pkt_ready_o on the next edge, go to ISSUE.
//  ISSUE, one cycle: register op_s/A_s/B_s from item idx, start=1, go to WAIT.
//   First start is at accept+1. op_s/A_s/B_s hold their values until the next ISSUE.
//  WAIT: start=0. On done=1: res_o<=res_i, item_idx_o<=idx, res_valid_o=1 next cycle.
//   If idx==NUM-1: also pulse pkt_done_o and go to IDLE, pkt_ready_o=1 the same cycle.
//   Otherwise idx<=idx+1 and go to ISSUE.
//   Minimum item period is 2 cycles (done in the first WAIT cycle).
//  done while in IDLE or ISSUE is ignored, with no state change.
//  pkt_valid_i while busy: packet not accepted. The source must hold it stable.
//  NUM=1: a single ISSUE/WAIT pass; pkt_done_o and res_valid_o pulse together.
//  idx never wraps inside a packet and resets to 0 on each accept.
// CONFIGURATION
//  `ALU_SEQ_TIMEOUT_EN defined:
//   - A watchdog counts cycles in WAIT.
//   - If TIMEOUT cycles pass with no done: set err_timeout_o (sticky until reset),
//     emit res_valid_o with res_o={RES_WIDTH{1'b1}} for that idx, then advance as if
//     done arrived.
//  Not defined: no counter; WAIT holds indefinitely; err_timeout_o=0.
// STRUCTURE
//  Package alu_seq_pkg:
//   - state enum {IDLE, ISSUE, WAIT}
//   - slot offsets OP_OFS=0, A_OFS=1, B_OFS=2; SLOTS_PER_ITEM=3
//   - RES_TIMEOUT_VAL constant
//  Sub-module alu_seq_watchdog, instantiated only under ALU_SEQ_TIMEOUT_EN:
//   - ports clk_i, reset_i, run, clear, expired
//   - counts while run, clears on clear
//  Item extraction is an indexed part-select inside the top module.
// TESTING
//  1 Reset release, pkt_valid_i=0 -> all outputs 0 during reset; pkt_ready_o=1 one edge after release.
//  2 NUM=3, items (op=1,A=5,B=7),(2,9,3),(7,255,1); bfm done 1 cycle after start
//    -> start at accept+1, +3, +5 with matching op/A/B;
//    -> res_valid_o x3 with item_idx_o 0,1,2; pkt_done_o coincides with idx 2.
//  3 op slot 8'hFD -> op_s=3'b101.
//  4 done forced high in IDLE and ISSUE -> no res_valid_o; only WAIT-cycle done is taken.
//  5 reset_i low during WAIT of item 1 -> outputs 0 at once.
//    -> new packet afterwards starts from item 0.
//  6 ALU_SEQ_TIMEOUT_EN, TIMEOUT=8, no done on item 0
//    -> res_o=16'hFFFF, idx 0, err_timeout_o=1 after 8 WAIT cycles; item 1 then issues.

Source files
------------

// File: rtl/alu_item_sequencer_pkg.sv
// Shared state type, payload slot layout and timeout fill value for the ALU item sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_e;

    localparam int OP_OFS         = 0;
    localparam int A_OFS          = 1;
    localparam int B_OFS          = 2;
    localparam int SLOTS_PER_ITEM = 3;

    // Replicated across the result width when an item times out.
    localparam logic RES_TIMEOUT_VAL = 1'b1;

    function automatic int unsigned slot_base(input int unsigned item,
                                              input int unsigned ofs,
                                              input int unsigned width);
        return (item * SLOTS_PER_ITEM + ofs) * width;
    endfunction

endpackage

// File: rtl/alu_item_sequencer_if.sv
// Start/done issue channel between the item sequencer (master) and the ALU bfm (slave).
interface alu_item_sequencer_if #(
    parameter int OP_WIDTH   = 3,
    parameter int ITEM_WIDTH = 8,
    parameter int RES_WIDTH  = 16
);
    logic [OP_WIDTH-1:0]   op_s;
    logic [ITEM_WIDTH-1:0] A_s;
    logic [ITEM_WIDTH-1:0] B_s;
    logic                  start;
    logic                  done;
    logic [RES_WIDTH-1:0]  res_i;

    modport master (output op_s, A_s, B_s, start, input done, res_i);
    modport slave  (input op_s, A_s, B_s, start, output done, res_i);
endinterface

// File: rtl/alu_item_sequencer_watchdog.sv
// WAIT-state watchdog: down-counter loaded with TIMEOUT-1, expires on terminal count while running.
module alu_seq_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic run,
    input  logic clear,
    output logic expired
);
    localparam int CNT_W = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = LOAD;
        end else if (run && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Reaching zero in a run cycle means TIMEOUT consecutive run cycles have elapsed.
    assign expired = run && !clear && (cnt_q == '0);

endmodule

// File: rtl/alu_item_sequencer.sv
// Accepts a packed packet of NUM ALU items and issues them one at a time to the bfm.
// Optional watchdog on the WAIT state is enabled by defining ALU_SEQ_TIMEOUT_EN.
//   state | meaning
//   IDLE  | ready for a packet, pkt_ready_o high
//   ISSUE | operands of item idx driven, start pulse high
//   WAIT  | waiting for bfm done (or watchdog expiry)
module alu_item_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NUM        = 100,
    parameter int ITEM_WIDTH = 8,
    parameter int OP_WIDTH   = 3,
    parameter int RES_WIDTH  = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                                        clk_i,
    input  logic                                        reset_i,
    input  logic                                        pkt_valid_i,
    output logic                                        pkt_ready_o,
    input  logic [NUM*SLOTS_PER_ITEM*ITEM_WIDTH-1:0]    pkt_data_i,
    alu_item_sequencer_if.master                        bfm,
    output logic                                        res_valid_o,
    output logic [RES_WIDTH-1:0]                        res_o,
    output logic [((NUM > 1) ? $clog2(NUM) : 1)-1:0]    item_idx_o,
    output logic                                        pkt_done_o,
    output logic                                        err_timeout_o
);
    localparam int PKT_W = NUM * SLOTS_PER_ITEM * ITEM_WIDTH;
    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

    seq_state_e            state_q, state_d;
    logic [PKT_W-1:0]      payload_q;
    logic [PKT_W-1:0]      item_src;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  ready_q, ready_d;
    logic                  start_q, start_d;
    logic                  res_valid_q, res_valid_d;
    logic                  pkt_done_q, pkt_done_d;
    logic                  err_q, err_d;
    logic [OP_WIDTH-1:0]   op_q, op_d;
    logic [ITEM_WIDTH-1:0] a_q, a_d;
    logic [ITEM_WIDTH-1:0] b_q, b_d;
    logic [RES_WIDTH-1:0]  res_q, res_d;
    logic [IDX_W-1:0]      item_idx_q, item_idx_d;
    logic                  accept;
    logic                  timed_out;

`ifdef ALU_SEQ_TIMEOUT_EN
    alu_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .run     (state_q == WAIT),
        .clear   (state_q != WAIT),
        .expired (timed_out)
    );
`else
    assign timed_out = 1'b0;
`endif

    assign accept = (state_q == IDLE) && pkt_valid_i && ready_q;

    // Item 0 issues the cycle after accept, before payload_q holds the packet.
    assign item_src = (state_q == IDLE) ? pkt_data_i : payload_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        start_d     = 1'b0;
        res_valid_d = 1'b0;
        pkt_done_d  = 1'b0;
        err_d       = err_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        item_idx_d  = item_idx_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bfm.done || timed_out) begin
                    res_valid_d = 1'b1;
                    item_idx_d  = idx_q;
                    res_d       = bfm.done ? bfm.res_i : {RES_WIDTH{RES_TIMEOUT_VAL}};
                    if (!bfm.done) begin
                        err_d = 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        pkt_done_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);

        if (state_d == ISSUE) begin
            start_d = 1'b1;
            op_d    = item_src[slot_base(int'(idx_d), OP_OFS, ITEM_WIDTH) +: OP_WIDTH];
            a_d     = item_src[slot_base(int'(idx_d), A_OFS, ITEM_WIDTH) +: ITEM_WIDTH];
            b_d     = item_src[slot_base(int'(idx_d), B_OFS, ITEM_WIDTH) +: ITEM_WIDTH];
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            ready_q     <= 1'b0;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
            pkt_done_q  <= 1'b0;
            err_q       <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            item_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ready_q     <= ready_d;
            start_q     <= start_d;
            res_valid_q <= res_valid_d;
            pkt_done_q  <= pkt_done_d;
            err_q       <= err_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            item_idx_q  <= item_idx_d;
        end
    end

    // Payload is data-only and deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            payload_q <= pkt_data_i;
        end
    end

    assign pkt_ready_o   = ready_q;
    assign bfm.op_s      = op_q;
    assign bfm.A_s       = a_q;
    assign bfm.B_s       = b_q;
    assign bfm.start     = start_q;
    assign res_valid_o   = res_valid_q;
    assign res_o         = res_q;
    assign item_idx_o    = item_idx_q;
    assign pkt_done_o    = pkt_done_q;
    assign err_timeout_o = err_q;

endmodule
